// File: rtl/sme_sched_pkg.sv
// sme_sched_pkg: shared FSM encoding, length limits and SME character constants
package sme_sched_pkg;
  typedef enum logic [2:0] {IDLE, STR, PAT, WAIT, RESP, GAP} state_t;
  localparam logic [5:0] MAX_STR_LEN = 6'd32;
  localparam logic [3:0] MAX_PAT_LEN = 4'd8;
  localparam logic [7:0] CH_BOL   = 8'h5E;
  localparam logic [7:0] CH_EOL   = 8'h24;
  localparam logic [7:0] CH_ANY   = 8'h2E;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  function automatic logic len_ok(input logic [5:0] s, input logic [3:0] p);
    return s != 6'd0 && s <= MAX_STR_LEN && p != 4'd0 && p <= MAX_PAT_LEN;
  endfunction
endpackage

// File: rtl/sme_rr_arb.sv
// sme_rr_arb: combinational round-robin pick, first requester at or after ptr
module sme_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int k;
  // scan offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k = 0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      k = (int'(ptr) + o) % NREQ;
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = IW'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sme_job_scheduler.sv
// sme_job_scheduler: shares one SME among NREQ requesters; string reuse via SME_STR_REUSE_EN
module sme_job_scheduler
  import sme_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*256-1:0] req_str,
  input  logic [NREQ*6-1:0] req_str_len,
  input  logic [NREQ*64-1:0] req_pat,
  input  logic [NREQ*4-1:0] req_pat_len,
  input  logic [NREQ-1:0]   req_keep_str,
  output logic [NREQ-1:0]   done,
  output logic              rsp_match,
  output logic [4:0]        rsp_index,
  output logic              rsp_err,
  output logic [7:0]        sme_chardata,
  output logic              sme_isstring,
  output logic              sme_ispattern,
  input  logic              sme_valid,
  input  logic              sme_match,
  input  logic [4:0]        sme_match_index
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [IW-1:0]   rr_ptr, g, gi;
  logic [NREQ-1:0] gnt, g_oh;
  logic            any, reuse;
  logic [255:0]    str_q, sel_str;
  logic [63:0]     pat_q, sel_pat;
  logic [5:0]      str_len_q, sel_str_len;
  logic [3:0]      pat_len_q, sel_pat_len;
  logic [4:0]      cnt;
  logic [TW-1:0]   timer;

  sme_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gi),
    .any(any)
  );

  assign sel_str     = req_str[int'(gi)*256 +: 256];
  assign sel_pat     = req_pat[int'(gi)*64 +: 64];
  assign sel_str_len = req_str_len[int'(gi)*6 +: 6];
  assign sel_pat_len = req_pat_len[int'(gi)*4 +: 4];
  assign g_oh        = NREQ'(1) << g;

`ifdef SME_STR_REUSE_EN
  logic [IW-1:0] loaded_owner;
  logic          loaded_vld;
  assign reuse = req_keep_str[gi] && loaded_vld && loaded_owner == gi;
  // track whose string the SME currently holds; a timeout leaves it unknown
  always_ff @(posedge clk) begin
    if (reset) begin
      loaded_owner <= '0;
      loaded_vld <= 1'b0;
    end else if (state == STR) begin
      loaded_owner <= g;
      loaded_vld <= 1'b1;
    end else if (state == WAIT && !sme_valid && timer == TW'(TIMEOUT - 1)) begin
      loaded_vld <= 1'b0;
    end
  end
`else
  logic unused_keep;
  assign unused_keep = ^req_keep_str;
  assign reuse = 1'b0;
`endif

  // job FSM; outputs are registered for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      g <= '0;
      str_q <= '0;
      pat_q <= '0;
      str_len_q <= '0;
      pat_len_q <= '0;
      cnt <= '0;
      timer <= '0;
      done <= '0;
      rsp_match <= 1'b0;
      rsp_index <= '0;
      rsp_err <= 1'b0;
      sme_chardata <= '0;
      sme_isstring <= 1'b0;
      sme_ispattern <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          g <= gi;
          str_q <= sel_str;
          pat_q <= sel_pat;
          str_len_q <= sel_str_len;
          pat_len_q <= sel_pat_len;
          cnt <= '0;
          if (!len_ok(sel_str_len, sel_pat_len)) begin
            state <= RESP;
            done <= gnt;
            rsp_err <= 1'b1;
            rsp_match <= 1'b0;
            rsp_index <= '0;
          end else if (reuse) begin
            state <= PAT;
            sme_ispattern <= 1'b1;
            sme_chardata <= sel_pat[7:0];
          end else begin
            state <= STR;
            sme_isstring <= 1'b1;
            sme_chardata <= sel_str[7:0];
          end
        end
        STR: if ({1'b0, cnt} == str_len_q - 6'd1) begin
          state <= PAT;
          cnt <= '0;
          sme_isstring <= 1'b0;
          sme_ispattern <= 1'b1;
          sme_chardata <= pat_q[7:0];
        end else begin
          cnt <= cnt + 5'd1;
          sme_chardata <= str_q[{cnt + 5'd1, 3'b000} +: 8];
        end
        PAT: if (cnt == {1'b0, pat_len_q - 4'd1}) begin
          state <= WAIT;
          timer <= '0;
          sme_ispattern <= 1'b0;
          sme_chardata <= '0;
        end else begin
          cnt <= cnt + 5'd1;
          sme_chardata <= pat_q[{cnt[2:0] + 3'd1, 3'b000} +: 8];
        end
        WAIT: if (sme_valid) begin
          state <= RESP;
          done <= g_oh;
          rsp_match <= sme_match;
          rsp_index <= sme_match_index;
          rsp_err <= 1'b0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state <= RESP;
          done <= g_oh;
          rsp_match <= 1'b0;
          rsp_index <= '0;
          rsp_err <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
        RESP: begin
          done <= '0;
          rr_ptr <= (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
          state <= GAP;
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_job_scheduler.sv
// tb_sme_job_scheduler: directed bench with a cycle-stepped SME response model
module tb_sme_job_scheduler;
  localparam int NREQ = 2;
  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req;
  logic [NREQ*256-1:0] req_str;
  logic [NREQ*6-1:0] req_str_len;
  logic [NREQ*64-1:0] req_pat;
  logic [NREQ*4-1:0] req_pat_len;
  logic [NREQ-1:0] req_keep_str;
  logic [NREQ-1:0] done;
  logic rsp_match, rsp_err;
  logic [4:0] rsp_index;
  logic [7:0] sme_chardata;
  logic sme_isstring, sme_ispattern;
  logic sme_valid, sme_match;
  logic [4:0] sme_match_index;

  sme_job_scheduler #(.NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_str(req_str), .req_str_len(req_str_len),
    .req_pat(req_pat), .req_pat_len(req_pat_len), .req_keep_str(req_keep_str),
    .done(done), .rsp_match(rsp_match), .rsp_index(rsp_index), .rsp_err(rsp_err),
    .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;
  int k, n_str, n_pat, s0_k, s1_k, first_pat_k, wait_k, d0_k, d1_k, ndone, idle_bad, wcnt;
  logic [255:0] sbuf;
  logic [63:0] pbuf;
  logic [NREQ-1:0] d0_v, d1_v;
  logic r_m, r_e, prev_pat, prev_str;
  logic [4:0] r_i;
  int sme_delay;
  bit sme_never, sme_m;
  logic [4:0] sme_idx;

  task automatic clear_obs();
    k = 0; n_str = 0; n_pat = 0; sbuf = '0; pbuf = '0;
    s0_k = -1; s1_k = -1; first_pat_k = -1; wait_k = -1;
    d0_k = -1; d1_k = -1; d0_v = '0; d1_v = '0; ndone = 0; idle_bad = 0;
  endtask

  task automatic step();
    @(negedge clk);
    k++;
    if (sme_isstring && !prev_str) begin
      if (ndone == 0 && s0_k < 0) s0_k = k;
      else if (ndone > 0 && s1_k < 0) s1_k = k;
    end
    if (sme_isstring) begin
      if (n_str < 32) sbuf[n_str*8 +: 8] = sme_chardata;
      n_str++;
    end
    if (sme_ispattern) begin
      if (first_pat_k < 0) first_pat_k = k;
      if (n_pat < 8) pbuf[n_pat*8 +: 8] = sme_chardata;
      n_pat++;
    end
    if (!sme_isstring && !sme_ispattern && sme_chardata != 8'h00) idle_bad++;
    if (done != '0) begin
      if (ndone == 0) begin
        d0_k = k; d0_v = done; r_m = rsp_match; r_i = rsp_index; r_e = rsp_err;
      end else if (ndone == 1) begin
        d1_k = k; d1_v = done;
      end
      ndone++;
    end
    sme_valid = 1'b0;
    if (reset) wcnt = -1;
    else if (prev_pat && !sme_ispattern) begin wcnt = 0; wait_k = k; end
    else if (wcnt >= 0) wcnt++;
    if (wcnt >= 0 && wcnt == sme_delay && !sme_never) begin
      sme_valid = 1'b1; sme_match = sme_m; sme_match_index = sme_idx; wcnt = -1;
    end
    prev_pat = sme_ispattern;
    prev_str = sme_isstring;
  endtask

  task automatic load(input int r, input logic [255:0] s, input logic [5:0] sl,
                      input logic [63:0] p, input logic [3:0] pl, input bit keep);
    req_str[r*256 +: 256] = s;
    req_str_len[r*6 +: 6] = sl;
    req_pat[r*64 +: 64] = p;
    req_pat_len[r*4 +: 4] = pl;
    req_keep_str[r] = keep;
  endtask

  task automatic run_one(input int r, input logic [255:0] s, input logic [5:0] sl,
                         input logic [63:0] p, input logic [3:0] pl, input bit keep);
    load(r, s, sl, p, pl, keep);
    clear_obs();
    req[r] = 1'b1;
    for (int i = 0; i < 300 && ndone == 0; i++) step();
    req[r] = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (done !== '0) begin nfail++; $display("FAIL reset_done got %b exp 00", done); end
    nvec++; if (rsp_match !== 1'b0) begin nfail++; $display("FAIL reset_match got %b exp 0", rsp_match); end
    nvec++; if (rsp_index !== 5'd0) begin nfail++; $display("FAIL reset_index got %0d exp 0", rsp_index); end
    nvec++; if (rsp_err !== 1'b0) begin nfail++; $display("FAIL reset_err got %b exp 0", rsp_err); end
    nvec++; if (sme_chardata !== 8'h00) begin nfail++; $display("FAIL reset_chardata got %h exp 00", sme_chardata); end
    nvec++; if ({sme_isstring, sme_ispattern} !== 2'b00) begin nfail++; $display("FAIL reset_strobes got %b exp 00", {sme_isstring, sme_ispattern}); end
    clear_obs();
    for (int i = 0; i < 4; i++) step();
    nvec++; if (ndone + n_str + n_pat !== 0) begin nfail++; $display("FAIL idle_quiet got %0d exp 0", ndone + n_str + n_pat); end
  endtask

  task automatic test_single();
    logic [255:0] s;
    logic [63:0] p;
    s = '0; s[23:0] = 24'h636261;
    p = '0; p[7:0] = 8'h62;
    sme_delay = 2; sme_never = 0; sme_m = 1; sme_idx = 5'd1;
    run_one(0, s, 6'd3, p, 4'd1, 1'b0);
    nvec++; if (s0_k !== 1) begin nfail++; $display("FAIL single_first_str got %0d exp 1", s0_k); end
    nvec++; if (n_str !== 3) begin nfail++; $display("FAIL single_n_str got %0d exp 3", n_str); end
    nvec++; if (sbuf[23:0] !== 24'h636261) begin nfail++; $display("FAIL single_str_bytes got %h exp 636261", sbuf[23:0]); end
    nvec++; if (first_pat_k !== 4) begin nfail++; $display("FAIL single_first_pat got %0d exp 4", first_pat_k); end
    nvec++; if (n_pat !== 1 || pbuf[7:0] !== 8'h62) begin nfail++; $display("FAIL single_pat got n=%0d b=%h exp n=1 b=62", n_pat, pbuf[7:0]); end
    nvec++; if (d0_k !== 8) begin nfail++; $display("FAIL single_done_k got %0d exp 8", d0_k); end
    nvec++; if (d0_v !== 2'b01) begin nfail++; $display("FAIL single_done got %b exp 01", d0_v); end
    nvec++; if ({r_m, r_i, r_e} !== {1'b1, 5'd1, 1'b0}) begin nfail++; $display("FAIL single_rsp got m=%b i=%0d e=%b exp m=1 i=1 e=0", r_m, r_i, r_e); end
    nvec++; if (ndone !== 1) begin nfail++; $display("FAIL single_pulse got %0d exp 1", ndone); end
    nvec++; if (idle_bad !== 0) begin nfail++; $display("FAIL single_idle_char got %0d exp 0", idle_bad); end
  endtask

  task automatic test_max_len();
    logic [255:0] s;
    logic [63:0] p;
    for (int i = 0; i < 32; i++) s[i*8 +: 8] = 8'(8'h40 + i);
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = 8'(8'h61 + i);
    sme_delay = 0; sme_m = 0; sme_idx = 5'd31;
    run_one(1, s, 6'd32, p, 4'd8, 1'b0);
    nvec++; if (n_str !== 32 || sbuf !== s) begin nfail++; $display("FAIL max_str got n=%0d exp 32 bytes_ok=%b", n_str, sbuf == s); end
    nvec++; if (n_pat !== 8 || pbuf !== p) begin nfail++; $display("FAIL max_pat got n=%0d b=%h exp n=8 b=%h", n_pat, pbuf, p); end
    nvec++; if (first_pat_k !== 33) begin nfail++; $display("FAIL max_first_pat got %0d exp 33", first_pat_k); end
    nvec++; if (d0_k !== 42 || d0_v !== 2'b10) begin nfail++; $display("FAIL max_done got k=%0d v=%b exp k=42 v=10", d0_k, d0_v); end
    nvec++; if ({r_m, r_i, r_e} !== {1'b0, 5'd31, 1'b0}) begin nfail++; $display("FAIL max_rsp got m=%b i=%0d e=%b exp m=0 i=31 e=0", r_m, r_i, r_e); end
  endtask

  task automatic test_len_err();
    run_one(0, 256'h61, 6'd0, 64'h62, 4'd1, 1'b0);
    nvec++; if (d0_k !== 1 || d0_v !== 2'b01) begin nfail++; $display("FAIL err_str0_done got k=%0d v=%b exp k=1 v=01", d0_k, d0_v); end
    nvec++; if (r_e !== 1'b1 || r_m !== 1'b0) begin nfail++; $display("FAIL err_str0_rsp got e=%b m=%b exp e=1 m=0", r_e, r_m); end
    nvec++; if (n_str + n_pat !== 0) begin nfail++; $display("FAIL err_str0_strobes got %0d exp 0", n_str + n_pat); end
    run_one(1, 256'h61, 6'd5, 64'h62, 4'd9, 1'b0);
    nvec++; if (d0_k !== 1 || d0_v !== 2'b10 || r_e !== 1'b1) begin nfail++; $display("FAIL err_pat9 got k=%0d v=%b e=%b exp k=1 v=10 e=1", d0_k, d0_v, r_e); end
    run_one(0, 256'h61, 6'd33, 64'h62, 4'd1, 1'b0);
    nvec++; if (d0_k !== 1 || r_e !== 1'b1 || n_str !== 0) begin nfail++; $display("FAIL err_str33 got k=%0d e=%b n=%0d exp k=1 e=1 n=0", d0_k, r_e, n_str); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    load(0, 256'h78, 6'd1, 64'h70, 4'd1, 1'b0);
    load(1, 256'h7A, 6'd1, 64'h71, 4'd1, 1'b0);
    sme_delay = 0; sme_m = 1; sme_idx = 5'd5;
    clear_obs();
    req = 2'b11;
    for (int i = 0; i < 100 && ndone < 2; i++) begin step(); req = req & ~done; end
    step(); step();
    nvec++; if (d0_v !== 2'b01 || d0_k !== 4) begin nfail++; $display("FAIL sim_first got v=%b k=%0d exp v=01 k=4", d0_v, d0_k); end
    nvec++; if (s1_k !== 7) begin nfail++; $display("FAIL sim_second_start got %0d exp 7", s1_k); end
    nvec++; if (d1_v !== 2'b10 || d1_k !== 10) begin nfail++; $display("FAIL sim_second got v=%b k=%0d exp v=10 k=10", d1_v, d1_k); end
    nvec++; if (sbuf[15:0] !== 16'h7A78) begin nfail++; $display("FAIL sim_bytes got %h exp 7a78", sbuf[15:0]); end
    clear_obs();
    req = 2'b11;
    for (int i = 0; i < 100 && ndone < 2; i++) begin step(); req = req & ~done; end
    step(); step();
    nvec++; if (d0_v !== 2'b01 || d1_v !== 2'b10) begin nfail++; $display("FAIL sim_rr_wrap got %b,%b exp 01,10", d0_v, d1_v); end
  endtask

  task automatic test_timeout();
    sme_never = 1;
    run_one(0, 256'h6261, 6'd2, 64'h61, 4'd1, 1'b0);
    nvec++; if (wait_k !== 4 || d0_k !== 68) begin nfail++; $display("FAIL timeout_k got wait=%0d done=%0d exp 4,68", wait_k, d0_k); end
    nvec++; if ({r_e, r_m, r_i} !== {1'b1, 1'b0, 5'd0}) begin nfail++; $display("FAIL timeout_rsp got e=%b m=%b i=%0d exp e=1 m=0 i=0", r_e, r_m, r_i); end
    sme_never = 0;
    run_one(0, 256'h6261, 6'd2, 64'h61, 4'd1, 1'b1);
    nvec++; if (n_str !== 2 || r_e !== 1'b0) begin nfail++; $display("FAIL timeout_next_str got n=%0d e=%b exp n=2 e=0", n_str, r_e); end
  endtask

  task automatic test_reuse();
    int exp_n, exp_p;
`ifdef SME_STR_REUSE_EN
    exp_n = 0; exp_p = 1;
`else
    exp_n = 5; exp_p = 6;
`endif
    run_one(0, 256'h6F6C6C6568, 6'd5, 64'h6C, 4'd1, 1'b0);
    run_one(0, 256'h6F6C6C6568, 6'd5, 64'h6C, 4'd1, 1'b1);
    nvec++; if (n_str !== exp_n || first_pat_k !== exp_p) begin nfail++; $display("FAIL reuse_keep got n=%0d p=%0d exp n=%0d p=%0d", n_str, first_pat_k, exp_n, exp_p); end
    nvec++; if (d0_v !== 2'b01 || r_m !== 1'b1) begin nfail++; $display("FAIL reuse_rsp got v=%b m=%b exp v=01 m=1", d0_v, r_m); end
    run_one(1, 256'h7978, 6'd2, 64'h78, 4'd1, 1'b0);
    run_one(0, 256'h6F6C6C6568, 6'd5, 64'h6C, 4'd1, 1'b1);
    nvec++; if (n_str !== 5) begin nfail++; $display("FAIL reuse_overwritten got %0d exp 5", n_str); end
  endtask

  task automatic test_reset_mid();
    sme_m = 1; sme_idx = 5'd7;
    run_one(0, 256'h6261, 6'd2, 64'h7A797877, 4'd4, 1'b0);
    load(0, 256'h6261, 6'd2, 64'h7A797877, 4'd4, 1'b1);
    clear_obs();
    req[0] = 1'b1;
    for (int i = 0; i < 20 && !sme_ispattern; i++) step();
    nvec++; if (sme_ispattern !== 1'b1) begin nfail++; $display("FAIL rst_mid_reach_pat got %b exp 1", sme_ispattern); end
    reset = 1'b1;
    req[0] = 1'b0;
    step();
    nvec++; if ({done, rsp_match, rsp_index, rsp_err, sme_chardata, sme_isstring, sme_ispattern} !== '0) begin
      nfail++; $display("FAIL rst_mid_outputs got d=%b m=%b i=%0d e=%b c=%h s=%b p=%b exp all 0", done, rsp_match, rsp_index, rsp_err, sme_chardata, sme_isstring, sme_ispattern);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    nvec++; if (ndone !== 0) begin nfail++; $display("FAIL rst_mid_no_done got %0d exp 0", ndone); end
    run_one(0, 256'h6261, 6'd2, 64'h7A797877, 4'd4, 1'b1);
    nvec++; if (n_str !== 2 || n_pat !== 4 || ndone !== 1) begin nfail++; $display("FAIL rst_mid_next got s=%0d p=%0d d=%0d exp 2,4,1", n_str, n_pat, ndone); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_str = '0; req_str_len = '0; req_pat = '0; req_pat_len = '0;
    req_keep_str = '0; sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    sme_delay = 0; sme_never = 0; sme_m = 0; sme_idx = '0;
    prev_pat = 1'b0; prev_str = 1'b0; wcnt = -1; r_m = 0; r_e = 0; r_i = '0;
    clear_obs();
    test_reset();
    test_single();
    test_max_len();
    test_len_err();
    test_simultaneous();
    test_timeout();
    test_reuse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
